// File: rtl/dnn_feed_pkg.sv
// Shared sizing helpers and the saturating counter step for the data_feed /
// sample_assembler path.
package dnn_feed_pkg;

    localparam int unsigned DEF_CPC   = 6;
    localparam int unsigned DEF_IN    = 16;
    localparam int unsigned DEF_OUT   = 4;
    localparam int unsigned DEF_CNT_W = 16;

    // Two clocks of every cycle block carry no chunk.
    function automatic int unsigned chunks_per_sample(input int unsigned cpc);
        return cpc - 2;
    endfunction

    function automatic int unsigned chunk_width(input int unsigned total, input int unsigned nc);
        return total / nc;
    endfunction

    // A single-chunk sample still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned nc);
        return (nc <= 1) ? 1 : $clog2(nc);
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/chunk_deser.sv
// Fill register for one vector: writes an indexed chunk slice and clears the
// partial contents when a new block starts.
module chunk_deser
    import dnn_feed_pkg::*;
#(
    parameter int unsigned TOTAL_W = 16,
    parameter int unsigned CHUNK_W = 4,
    parameter int unsigned NC      = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic               i_sync,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [CHUNK_W-1:0] i_chunk,
    output logic [TOTAL_W-1:0] o_fill_next
);

    logic [TOTAL_W-1:0] r_fill;
    logic [TOTAL_W-1:0] w_fill_next;

    // Merge the incoming chunk into its slot; chunk data is never looked at
    // unless i_we is set, so idle-cycle X cannot leak into the fill.
    always_comb begin
        w_fill_next = r_fill;
        if (i_we) begin
            if (i_sync) begin
                w_fill_next = '0;
            end
            for (int unsigned k = 0; k < NC; k++) begin
                if (i_idx == IDX_W'(k)) begin
                    w_fill_next[k*CHUNK_W +: CHUNK_W] = i_chunk;
                end
            end
        end
    end

    // Fill register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fill <= '0;
        end else begin
            r_fill <= w_fill_next;
        end
    end

    assign o_fill_next = w_fill_next;

endmodule

// File: rtl/sample_assembler.sv
// Reassembles data_feed chunk streams into full samples and presents them on
// a valid/ready handshake with drop detection and delivery counters.
module sample_assembler
    import dnn_feed_pkg::*;
#(
    parameter int unsigned CPC   = DEF_CPC,
    parameter int unsigned IN    = DEF_IN,
    parameter int unsigned OUT   = DEF_OUT,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sync,
    input  logic [IN/(CPC-2)-1:0]   act_chunk,
    input  logic [OUT/(CPC-2)-1:0]  y_chunk,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IN-1:0]           act_out,
    output logic [OUT-1:0]          y_out,
    output logic                    overflow,
    output logic [CNT_W-1:0]        sample_count,
    output logic [CNT_W-1:0]        drop_count
);

    localparam int unsigned NC    = chunks_per_sample(CPC);
    localparam int unsigned AW    = chunk_width(IN, NC);
    localparam int unsigned YW    = chunk_width(OUT, NC);
    localparam int unsigned IDX_W = idx_width(NC);

    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic [IN-1:0]    r_act;
    logic [OUT-1:0]   r_y;
    logic             r_overflow;
    logic [CNT_W-1:0] r_sample_count;
    logic [CNT_W-1:0] r_drop_count;

    logic [IDX_W-1:0] w_eff_idx;
    logic             w_last;
    logic             w_fire;
    logic             w_free;
    logic [IN-1:0]    w_act_next;
    logic [OUT-1:0]   w_y_next;

    // A sync chunk always lands in slot 0 regardless of the running index.
    assign w_eff_idx = in_sync ? '0 : r_idx;
    assign w_last    = in_valid && (w_eff_idx == IDX_W'(NC - 1));
    assign w_fire    = r_valid && out_ready;
    assign w_free    = !r_valid || out_ready;

    chunk_deser #(
        .TOTAL_W (IN),
        .CHUNK_W (AW),
        .NC      (NC),
        .IDX_W   (IDX_W)
    ) u_act_deser (
        .clk         (clk),
        .reset       (reset),
        .i_we        (in_valid),
        .i_sync      (in_sync),
        .i_idx       (w_eff_idx),
        .i_chunk     (act_chunk),
        .o_fill_next (w_act_next)
    );

    chunk_deser #(
        .TOTAL_W (OUT),
        .CHUNK_W (YW),
        .NC      (NC),
        .IDX_W   (IDX_W)
    ) u_y_deser (
        .clk         (clk),
        .reset       (reset),
        .i_we        (in_valid),
        .i_sync      (in_sync),
        .i_idx       (w_eff_idx),
        .i_chunk     (y_chunk),
        .o_fill_next (w_y_next)
    );

    // Chunk index: advances per accepted chunk, wraps after the last one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (in_valid) begin
            r_idx <= w_last ? '0 : w_eff_idx + IDX_W'(1);
        end
    end

    // Output register, handshake, drop flag and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid        <= 1'b0;
            r_act          <= '0;
            r_y            <= '0;
            r_overflow     <= 1'b0;
            r_sample_count <= '0;
            r_drop_count   <= '0;
        end else begin
            if (w_last && w_free) begin
                r_valid <= 1'b1;
                r_act   <= w_act_next;
                r_y     <= w_y_next;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            if (w_last && !w_free) begin
                r_overflow   <= 1'b1;
                r_drop_count <= CNT_W'(sat_inc(64'(r_drop_count), CNT_W));
            end
            if (w_fire) begin
                r_sample_count <= CNT_W'(sat_inc(64'(r_sample_count), CNT_W));
            end
        end
    end

    assign out_valid    = r_valid;
    assign act_out      = r_act;
    assign y_out        = r_y;
    assign overflow     = r_overflow;
    assign sample_count = r_sample_count;
    assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_sample_assembler.sv
// Self-checking bench for sample_assembler (CPC=6, IN=16, OUT=4).
module tb_sample_assembler;

    localparam int unsigned CPC   = 6;
    localparam int unsigned IN    = 16;
    localparam int unsigned OUT   = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned NC    = CPC - 2;
    localparam int unsigned AW    = IN / NC;
    localparam int unsigned YW    = OUT / NC;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_sync;
    logic [AW-1:0]     act_chunk;
    logic [YW-1:0]     y_chunk;
    logic              out_valid;
    logic              out_ready;
    logic [IN-1:0]     act_out;
    logic [OUT-1:0]    y_out;
    logic              overflow;
    logic [CNT_W-1:0]  sample_count;
    logic [CNT_W-1:0]  drop_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic              m_valid;
    logic [IN-1:0]     m_act;
    logic [OUT-1:0]    m_y;
    logic              m_ovf;
    int unsigned       m_cnt;
    int unsigned       m_drop;
    logic [AW-1:0]     q_act[$];
    logic [YW-1:0]     q_y[$];

    always #5 clk = ~clk;

    sample_assembler #(
        .CPC   (CPC),
        .IN    (IN),
        .OUT   (OUT),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_sync      (in_sync),
        .act_chunk    (act_chunk),
        .y_chunk      (y_chunk),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .act_out      (act_out),
        .y_out        (y_out),
        .overflow     (overflow),
        .sample_count (sample_count),
        .drop_count   (drop_count)
    );

    // Apply the rules of one clock edge to the model using the present inputs.
    task automatic model_step();
        logic          fire, free, complete;
        logic [IN-1:0] a;
        logic [OUT-1:0] y;
        fire = m_valid && out_ready;
        free = !m_valid || out_ready;
        complete = 1'b0;
        a = '0;
        y = '0;
        if (!reset) begin
            m_valid = 1'b0; m_act = '0; m_y = '0; m_ovf = 1'b0;
            m_cnt = 0; m_drop = 0;
            q_act.delete(); q_y.delete();
            return;
        end
        if (in_valid) begin
            if (in_sync) begin
                q_act.delete(); q_y.delete();
            end
            q_act.push_back(act_chunk);
            q_y.push_back(y_chunk);
            if (q_act.size() == NC) begin
                for (int k = 0; k < int'(NC); k++) begin
                    a = a | (IN'(q_act[k]) << (k * AW));
                    y = y | (OUT'(q_y[k]) << (k * YW));
                end
                complete = 1'b1;
                q_act.delete(); q_y.delete();
            end
        end
        if (complete && free) begin
            m_valid = 1'b1; m_act = a; m_y = y;
        end else if (fire) begin
            m_valid = 1'b0;
        end
        if (complete && !free) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
        if (fire && m_cnt < 65535) m_cnt++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chunk(input logic [AW-1:0] a, input logic [YW-1:0] y, input logic sync);
        in_valid  = 1'b1;
        in_sync   = sync;
        act_chunk = a;
        y_chunk   = y;
        tick();
        in_valid  = 1'b0;
        in_sync   = 1'($urandom);
        act_chunk = AW'($urandom);
        y_chunk   = YW'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({out_valid, act_out, y_out, overflow, sample_count, drop_count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b act=%h y=%b ovf=%b cnt=%0d drop=%0d, want all 0",
                     out_valid, act_out, y_out, overflow, sample_count, drop_count);
        end
        reset = 1'b1;
        send_chunk(4'hf, 1'b1, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || act_out !== 16'h000f || y_out !== 4'b0001) begin
            n_err++;
            $display("FAIL first_sample: got v=%b act=%h y=%b, want v=1 act=000f y=0001",
                     out_valid, act_out, y_out);
        end
        tick();
        n_vec++;
        if (sample_count !== 16'd1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL first_handshake: got cnt=%0d v=%b, want cnt=1 v=0", sample_count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'hf, 1'b1, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || act_out !== 16'h00f0 || y_out !== 4'b0010) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b act=%h y=%b, want v=1 act=00f0 y=0010",
                         i, out_valid, act_out, y_out);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || sample_count !== 16'd2) begin
            n_err++;
            $display("FAIL bp_release: got v=%b cnt=%0d, want v=0 cnt=2", out_valid, sample_count);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'hf, 1'b1, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'hf, 1'b1, 1'b0);
        n_vec++;
        if (act_out !== 16'h0f00 || y_out !== 4'b0100 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            n_err++;
            $display("FAIL overflow_drop: got act=%h y=%b ovf=%b drop=%0d, want act=0f00 y=0100 ovf=1 drop=1",
                     act_out, y_out, overflow, drop_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (overflow !== 1'b1 || out_valid !== 1'b0 || sample_count !== 16'd3) begin
            n_err++;
            $display("FAIL overflow_sticky: got ovf=%b v=%b cnt=%0d, want ovf=1 v=0 cnt=3",
                     overflow, out_valid, sample_count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send_chunk(4'h4, 1'b0, 1'b0);
        send_chunk(4'h3, 1'b1, 1'b0);
        send_chunk(4'h2, 1'b0, 1'b0);
        send_chunk(4'h1, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || act_out !== 16'h1234 || y_out !== 4'b1010) begin
            n_err++;
            $display("FAIL b2b_first: got v=%b act=%h y=%b, want v=1 act=1234 y=1010", out_valid, act_out, y_out);
        end
        send_chunk(4'h0, 1'b0, 1'b0);
        send_chunk(4'hf, 1'b1, 1'b0);
        send_chunk(4'hf, 1'b1, 1'b0);
        out_ready = 1'b1;
        send_chunk(4'hf, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || act_out !== 16'hfff0 || y_out !== 4'b1110 ||
            drop_count !== 16'd1 || sample_count !== 16'd4) begin
            n_err++;
            $display("FAIL b2b_switch: got v=%b act=%h y=%b drop=%0d cnt=%0d, want v=1 act=fff0 y=1110 drop=1 cnt=4",
                     out_valid, act_out, y_out, drop_count, sample_count);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || sample_count !== 16'd5) begin
            n_err++;
            $display("FAIL b2b_drain: got v=%b cnt=%0d, want v=0 cnt=5", out_valid, sample_count);
        end
    endtask

    task automatic test_resync();
        out_ready = 1'b1;
        send_chunk(4'h9, 1'b1, 1'b0);
        send_chunk(4'h6, 1'b0, 1'b0);
        send_chunk(4'hf, 1'b1, 1'b1);
        send_chunk(4'hf, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL resync_partial: got v=%b act=%h, want v=0", out_valid, act_out);
        end
        send_chunk(4'hf, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL resync_partial2: got v=%b act=%h, want v=0", out_valid, act_out);
        end
        send_chunk(4'h0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || act_out !== 16'h0fff || y_out !== 4'b0111) begin
            n_err++;
            $display("FAIL resync_sample: got v=%b act=%h y=%b, want v=1 act=0fff y=0111",
                     out_valid, act_out, y_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0]  a[4];
        logic [YW-1:0]  y[4];
        logic [IN-1:0]  ea;
        logic [OUT-1:0] ey;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_chunk(AW'($urandom), YW'($urandom), 1'b0);
        send_chunk(4'h5, 1'b1, 1'b0);
        send_chunk(4'ha, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_vec++;
        if ({out_valid, act_out, y_out, overflow, sample_count, drop_count} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b act=%h y=%b ovf=%b cnt=%0d drop=%0d, want all 0",
                     out_valid, act_out, y_out, overflow, sample_count, drop_count);
        end
        out_ready = 1'b1;
        ea = '0;
        ey = '0;
        for (int k = 0; k < 4; k++) begin
            a[k] = AW'($urandom);
            y[k] = YW'($urandom);
            ea[k*AW +: AW] = a[k];
            ey[k*YW +: YW] = y[k];
            send_chunk(a[k], y[k], 1'b0);
        end
        n_vec++;
        if (out_valid !== 1'b1 || act_out !== ea || y_out !== ey) begin
            n_err++;
            $display("FAIL reset_mid_reassemble: got v=%b act=%h y=%b, want v=1 act=%h y=%b",
                     out_valid, act_out, y_out, ea, ey);
        end
        tick();
    endtask

    task automatic test_random();
        out_ready = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sync   = ($urandom_range(0, 9) == 0);
            act_chunk = AW'($urandom);
            y_chunk   = YW'($urandom);
            out_ready = ($urandom_range(0, 9) < 4);
            tick();
            n_vec++;
            if (out_valid !== m_valid || (m_valid && (act_out !== m_act || y_out !== m_y)) ||
                overflow !== m_ovf || sample_count !== CNT_W'(m_cnt) || drop_count !== CNT_W'(m_drop)) begin
                n_err++;
                $display("FAIL random[%0d]: got v=%b act=%h y=%b ovf=%b cnt=%0d drop=%0d, want v=%b act=%h y=%b ovf=%b cnt=%0d drop=%0d",
                         i, out_valid, act_out, y_out, overflow, sample_count, drop_count,
                         m_valid, m_act, m_y, m_ovf, m_cnt, m_drop);
            end
        end
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sync   = 1'b0;
        act_chunk = '0;
        y_chunk   = '0;
        out_ready = 1'b0;
        m_valid = 1'b0; m_act = '0; m_y = '0; m_ovf = 1'b0; m_cnt = 0; m_drop = 0;
        test_reset();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
